// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline sequencing controller with debug run/halt/step FSM
// Combinational stage controls, per-stage valid tracking, retire and load-use stall counters.
module pipeline_ctrl #(
    parameter int CNT_W      = 32,
    parameter bit RESET_HALT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_use_hazard,
    input  logic             branch_taken_x,
    input  logic             halt_req,
    input  logic             resume_req,
    input  logic             step_req,
    output logic             pc_en,
    output logic             pc_sel_branch,
    output logic             stall_fd,
    output logic             flush_d,
    output logic             bubble_x,
    output logic             halted,
    output logic             step_done,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_STEP   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       step_flag;
    logic       v_d, v_x, v_m, v_w;
    logic       fetch_ok;
    logic       ld_stall;
    logic       pipe_empty;

    assign pipe_empty = ~(v_d | v_x | v_m | v_w);

    // A taken branch outranks everything, including a concurrent load-use stall.
    always_comb begin
        pc_en         = 1'b0;
        pc_sel_branch = 1'b0;
        stall_fd      = 1'b0;
        flush_d       = 1'b0;
        bubble_x      = 1'b0;
        fetch_ok      = 1'b0;
        ld_stall      = 1'b0;
        if (!rst) begin
            if (branch_taken_x) begin
                pc_en         = 1'b1;
                pc_sel_branch = 1'b1;
                flush_d       = 1'b1;
                bubble_x      = 1'b1;
            end else begin
                case (state)
                    S_RUN: begin
                        if (ld_use_hazard) begin
                            stall_fd = 1'b1;
                            bubble_x = 1'b1;
                            ld_stall = 1'b1;
                        end else begin
                            pc_en    = 1'b1;
                            fetch_ok = 1'b1;
                        end
                    end
                    S_STEP: begin
                        pc_en    = 1'b1;
                        fetch_ok = 1'b1;
                    end
                    default: flush_d = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RUN:    if (halt_req) state_next = S_DRAIN;
            S_DRAIN:  if (pipe_empty) state_next = S_HALTED;
            S_HALTED: begin
                if (halt_req)        state_next = S_HALTED;
                else if (resume_req) state_next = S_RUN;
                else if (step_req)   state_next = S_STEP;
            end
            default:  state_next = S_DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RESET_HALT ? S_HALTED : S_RUN;
            step_flag <= 1'b0;
            v_d       <= 1'b0;
            v_x       <= 1'b0;
            v_m       <= 1'b0;
            v_w       <= 1'b0;
            instret   <= '0;
            stall_cnt <= '0;
            halted    <= RESET_HALT;
            step_done <= 1'b0;
        end else begin
            state <= state_next;
            // DRAIN remembers whether it was entered from a single step.
            if (state == S_RUN)
                step_flag <= 1'b0;
            else if (state == S_STEP)
                step_flag <= 1'b1;
            v_w       <= v_m;
            v_m       <= v_x;
            v_x       <= v_d & ~bubble_x;
            v_d       <= stall_fd ? v_d : (fetch_ok & ~flush_d);
            instret   <= instret + {{(CNT_W-1){1'b0}}, v_w};
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, ld_stall};
            halted    <= (state_next == S_HALTED);
            step_done <= (state == S_DRAIN) && pipe_empty && step_flag;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - cycle-tagged scoreboard bench for pipeline_ctrl (run-reset and halt-reset instances)
module tb_pipeline_ctrl;

    localparam int ID_CTRL    = 0;
    localparam int ID_HALTED  = 1;
    localparam int ID_STEPD   = 2;
    localparam int ID_INSTRET = 3;
    localparam int ID_STALLC  = 4;
    localparam int ID_H_CTRL  = 5;
    localparam int ID_H_HALT  = 6;
    localparam int ID_H_STEPD = 7;
    localparam int ID_H_INST  = 8;

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] val;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   h_done = 1'b0;
    exp_t sb[$];
    logic [31:0] mon_act;

    logic rst, ld_use_hazard, branch_taken_x, halt_req, resume_req, step_req;
    logic pc_en, pc_sel_branch, stall_fd, flush_d, bubble_x, halted, step_done;
    logic [31:0] instret, stall_cnt;

    logic h_rst, h_ld, h_br, h_halt, h_resume, h_step;
    logic h_pc_en, h_pc_sel, h_stall_fd, h_flush_d, h_bubble_x, h_halted, h_step_done;
    logic [31:0] h_instret, h_stall_cnt;

    pipeline_ctrl #(.CNT_W(32), .RESET_HALT(1'b0)) u_dut (
        .clk(clk), .rst(rst), .ld_use_hazard(ld_use_hazard), .branch_taken_x(branch_taken_x),
        .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req),
        .pc_en(pc_en), .pc_sel_branch(pc_sel_branch), .stall_fd(stall_fd), .flush_d(flush_d),
        .bubble_x(bubble_x), .halted(halted), .step_done(step_done),
        .instret(instret), .stall_cnt(stall_cnt)
    );

    pipeline_ctrl #(.CNT_W(32), .RESET_HALT(1'b1)) u_dut_h (
        .clk(clk), .rst(h_rst), .ld_use_hazard(h_ld), .branch_taken_x(h_br),
        .halt_req(h_halt), .resume_req(h_resume), .step_req(h_step),
        .pc_en(h_pc_en), .pc_sel_branch(h_pc_sel), .stall_fd(h_stall_fd), .flush_d(h_flush_d),
        .bubble_x(h_bubble_x), .halted(h_halted), .step_done(h_step_done),
        .instret(h_instret), .stall_cnt(h_stall_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_sig(input int id);
        case (id)
            ID_CTRL:    get_sig = {27'd0, pc_en, pc_sel_branch, stall_fd, flush_d, bubble_x};
            ID_HALTED:  get_sig = {31'd0, halted};
            ID_STEPD:   get_sig = {31'd0, step_done};
            ID_INSTRET: get_sig = instret;
            ID_STALLC:  get_sig = stall_cnt;
            ID_H_CTRL:  get_sig = {27'd0, h_pc_en, h_pc_sel, h_stall_fd, h_flush_d, h_bubble_x};
            ID_H_HALT:  get_sig = {31'd0, h_halted};
            ID_H_STEPD: get_sig = {31'd0, h_step_done};
            ID_H_INST:  get_sig = h_instret;
            default:    get_sig = 32'hdead_beef;
        endcase
    endfunction

    task automatic expect_at(input int c, input int id, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc = c;
        e.id  = id;
        e.val = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every queued expectation tagged with the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                checks = checks + 1;
                mon_act = get_sig(sb[i].id);
                if (sb[i].cyc < cyc) begin
                    errors = errors + 1;
                    $display("FAIL %s: expectation for cycle %0d expired at cycle %0d", sb[i].nm, sb[i].cyc, cyc);
                end else if (mon_act !== sb[i].val) begin
                    errors = errors + 1;
                    $display("FAIL %s @cycle %0d: got %0h required %0h", sb[i].nm, cyc, mon_act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        h_rst = 1'b1; h_ld = 1'b0; h_br = 1'b0; h_halt = 1'b0; h_resume = 1'b0; h_step = 1'b0;
        expect_at(1, ID_H_HALT, 32'd1, "h_reset_halted");
        expect_at(1, ID_H_CTRL, 32'd0, "h_reset_ctrl");
        expect_at(1, ID_H_INST, 32'd0, "h_reset_instret");
        wait_cyc(2);
        h_rst = 1'b0;
        expect_at(3, ID_H_CTRL, 32'b00010, "h_halted_ctrl");
        expect_at(3, ID_H_HALT, 32'd1, "h_halted_level");
        wait_cyc(4);
        h_step = 1'b1;
        expect_at(5, ID_H_CTRL, 32'b10000, "h_step_fetch");
        expect_at(5, ID_H_HALT, 32'd0, "h_step_halted_low");
        wait_cyc(5);
        h_step = 1'b0;
        wait_cyc(7);
        h_rst = 1'b1;
        expect_at(7, ID_H_HALT, 32'd0, "h_drain_halted_low");
        expect_at(7, ID_H_CTRL, 32'd0, "h_rst_ctrl_gated");
        wait_cyc(8);
        h_rst = 1'b0;
        expect_at(8, ID_H_HALT, 32'd1, "h_rst_mid_drain_halted");
        expect_at(8, ID_H_STEPD, 32'd0, "h_rst_no_step_done");
        expect_at(8, ID_H_INST, 32'd0, "h_rst_instret_clear");
        expect_at(8, ID_H_CTRL, 32'b00010, "h_rst_ctrl_halted");
        expect_at(11, ID_H_STEPD, 32'd0, "h_no_late_step_done");
        expect_at(12, ID_H_INST, 32'd0, "h_valids_discarded");
        expect_at(12, ID_H_HALT, 32'd1, "h_stays_halted");
        wait_cyc(13);
        h_done = 1'b1;
    end

    initial begin
        rst = 1'b1; ld_use_hazard = 1'b0; branch_taken_x = 1'b0;
        halt_req = 1'b0; resume_req = 1'b0; step_req = 1'b0;
        expect_at(1, ID_CTRL, 32'd0, "reset_ctrl");
        expect_at(1, ID_HALTED, 32'd0, "reset_halted");
        expect_at(1, ID_INSTRET, 32'd0, "reset_instret");
        expect_at(1, ID_STALLC, 32'd0, "reset_stall_cnt");
        wait_cyc(2);
        rst = 1'b0;
        for (int c = 2; c < 12; c++) expect_at(c, ID_CTRL, 32'b10000, "run_pc_en");
        expect_at(6, ID_INSTRET, 32'd0, "first_retire_pending");
        expect_at(7, ID_INSTRET, 32'd1, "first_retire");
        expect_at(16, ID_INSTRET, 32'd10, "ten_retired");
        expect_at(16, ID_STALLC, 32'd0, "no_stalls_yet");

        wait_cyc(17);
        ld_use_hazard = 1'b1;
        expect_at(17, ID_CTRL, 32'b00101, "ld_use_ctrl");
        expect_at(18, ID_STALLC, 32'd1, "ld_use_stall_cnt");
        wait_cyc(18);
        ld_use_hazard = 1'b0;
        expect_at(18, ID_CTRL, 32'b10000, "ld_use_one_cycle");
        expect_at(20, ID_INSTRET, 32'd14, "pre_bubble_instret");
        expect_at(21, ID_INSTRET, 32'd14, "bubble_no_retire");
        expect_at(22, ID_INSTRET, 32'd15, "post_bubble_instret");

        wait_cyc(24);
        branch_taken_x = 1'b1;
        ld_use_hazard  = 1'b1;
        expect_at(24, ID_CTRL, 32'b11011, "redirect_over_ld_use");
        expect_at(25, ID_STALLC, 32'd1, "redirect_no_stall_count");
        wait_cyc(25);
        branch_taken_x = 1'b0;
        ld_use_hazard  = 1'b0;
        expect_at(27, ID_INSTRET, 32'd20, "pre_wrong_path");
        expect_at(29, ID_INSTRET, 32'd20, "wrong_path_not_retired");
        expect_at(30, ID_INSTRET, 32'd21, "post_wrong_path");

        wait_cyc(32);
        halt_req = 1'b1;
        expect_at(32, ID_CTRL, 32'b10000, "halt_cycle_still_runs");
        expect_at(32, ID_INSTRET, 32'd23, "instret_at_halt");
        wait_cyc(33);
        halt_req = 1'b0;
        for (int c = 33; c < 38; c++) expect_at(c, ID_CTRL, 32'b00010, "drain_no_fetch");
        expect_at(37, ID_HALTED, 32'd0, "drain_not_halted");
        expect_at(38, ID_HALTED, 32'd1, "halted_after_drain");
        expect_at(38, ID_INSTRET, 32'd28, "drain_retired_inflight");
        expect_at(40, ID_INSTRET, 32'd28, "halted_instret_stable");

        wait_cyc(40);
        step_req = 1'b1;
        expect_at(40, ID_CTRL, 32'b00010, "halted_ctrl");
        expect_at(41, ID_CTRL, 32'b10000, "step_single_fetch");
        expect_at(41, ID_HALTED, 32'd0, "step_halted_low");
        expect_at(42, ID_CTRL, 32'b00010, "step_then_drain");
        expect_at(45, ID_INSTRET, 32'd28, "step_not_yet_retired");
        expect_at(46, ID_INSTRET, 32'd29, "step_retired");
        expect_at(46, ID_STEPD, 32'd0, "step_done_not_early");
        expect_at(46, ID_HALTED, 32'd0, "step_drain_halted_low");
        expect_at(47, ID_STEPD, 32'd1, "step_done_pulse");
        expect_at(47, ID_HALTED, 32'd1, "step_halted_again");
        expect_at(48, ID_STEPD, 32'd0, "step_done_one_cycle");
        wait_cyc(41);
        step_req = 1'b0;

        wait_cyc(50);
        resume_req = 1'b1;
        step_req   = 1'b1;
        expect_at(50, ID_CTRL, 32'b00010, "halted_before_resume");
        expect_at(51, ID_CTRL, 32'b10000, "resume_runs");
        expect_at(51, ID_HALTED, 32'd0, "resume_halted_low");
        expect_at(52, ID_CTRL, 32'b10000, "resume_beats_step");
        expect_at(52, ID_INSTRET, 32'd29, "resume_instret");
        wait_cyc(51);
        resume_req = 1'b0;
        step_req   = 1'b0;

        wait_cyc(60);
        for (int k = 0; k < 100 && !h_done; k++) begin
            @(posedge clk);
            #1;
        end
        if (!h_done) begin
            errors = errors + 1;
            $display("FAIL h_sequence: not complete within bound");
        end
        while (sb.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s: expectation for cycle %0d never checked", sb[0].nm, sb[0].cyc);
            sb.delete(0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
